npc_redirect_ctrl: RTL
======================

NPC_REDIRECT_CTRL -- requirements
Module: npc_redirect_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush stays asserted after a redirect (legal 1..7).
REQ-002 SHALL have parameter PC_WIDTH, default 32, width of all PC buses.
REQ-003 SHALL have ports, in order:
- cpu_clk  in  1  sole clock, rising edge.
- cpu_rst  in  1  reset, synchronous, active-high.
- suspend  in  1  pipeline stall; blocks PC update.
- cur_pc  in  PC_WIDTH  current PC register value.
- pred_taken  in  1  predictor says taken.
- pred_target  in  PC_WIDTH  predicted target.
- sync_we  in  1  debug-sync redirect request, priority 1 (highest).
- sync_pc  in  PC_WIDTH  target for sync_we.
- exc_req  in  1  exception redirect, priority 2.
- exc_pc  in  PC_WIDTH  exception entry.
- br_err  in  1  branch mispredict, priority 3.
- br_pc  in  PC_WIDTH  corrected branch target.
- sync_inc  in  1  skip unimplemented inst, priority 4; target cur_pc+4.
- npc  out  PC_WIDTH  next PC to load.
- pc_we  out  1  PC register write enable.
- flush  out  1  kill IF/ID contents.
- if_valid  out  1  IF stage holds a valid fetch.
- redir_busy  out  1  state != IDLE.
- redir_cnt  out  32  redirects issued (stats).
- mispred_cnt  out  32  br_err redirects issued (stats).

Function
REQ-004 SHALL implement states IDLE, HOLD, FLUSH; all outputs combinational from state, registers and inputs (0-cycle select latency).
REQ-005 Priority SHALL be sync_we > exc_req > br_err > sync_inc; exactly one winner; npc arithmetic modulo 2^PC_WIDTH (cur_pc+4 wraps).
REQ-006 IDLE, no request, suspend=0: pc_we=1, npc = pred_taken ? pred_target : cur_pc+4, flush=0, if_valid=1.
REQ-007 IDLE, no request, suspend=1: pc_we=0, flush=0, if_valid=0, npc don't-care.
REQ-008 sync_we SHALL redirect in the same cycle from any state, ignoring suspend: pc_we=1, npc=sync_pc, flush=1, pending request discarded, then FLUSH (or IDLE if FLUSH_CYCLES=1).
REQ-009 IDLE/FLUSH, other request, suspend=0: pc_we=1, npc=winner target, flush=1, count loaded to FLUSH_CYCLES-1, next state FLUSH (IDLE if FLUSH_CYCLES=1).
REQ-010 IDLE/FLUSH, other request, suspend=1: latch winner target and source into pend regs, pc_we=0, next state HOLD.
REQ-011 HOLD: new request of strictly higher priority than pend source SHALL overwrite pend; equal/lower ignored; pc_we=0, flush=1, if_valid=0 while suspend=1.
REQ-012 HOLD, suspend=0: pc_we=1, npc=pend_pc (or new higher-priority winner same cycle), flush=1, then as REQ-009.
REQ-013 FLUSH, no request: flush=1, if_valid=0, pc_we=!suspend with sequential npc per REQ-006; count decrements each cycle (also during suspend); count==0 SHALL return to IDLE.
REQ-014 A redirect in FLUSH SHALL restart count.
REQ-015 redir_busy SHALL equal (state != IDLE).

Reset
REQ-016 cpu_rst high on a rising edge SHALL force state IDLE, count 0, pend cleared, stats 0; mid-operation HOLD/FLUSH abandoned.
REQ-017 While cpu_rst high: pc_we=0, flush=1, if_valid=0, npc=0.

Configuration
REQ-018 Macro REDIRECT_STATS_EN defined: redir_cnt increments per issued redirect (pc_we=1 with flush due to request), mispred_cnt per issued br_err redirect; both saturate at 32'hFFFF_FFFF.
REQ-019 Macro undefined: counters not built; redir_cnt, mispred_cnt tied to 0; ports remain.

Structure
REQ-020 Shared package npc_pkg SHALL hold state enum (IDLE/HOLD/FLUSH), source encoding (NONE/SYNC/EXC/BR/INC), and PC_INIT_VAL.
REQ-021 One sub-module npc_prio_sel SHALL implement the combinational priority pick (winner source + target).

Verification
REQ-022 Idle, cur_pc=0x1C000000, pred_taken=0 -> npc=0x1C000004, pc_we=1, flush=0.
REQ-023 br_err=1, br_pc=0x1C000100, FLUSH_CYCLES=2 -> same cycle npc=0x1C000100, pc_we=1; flush high 2 cycles, mispred_cnt=1.
REQ-024 suspend=1, br_err pulse (0x200), then exc_req pulse (0x300) -> HOLD, pend=0x300; suspend drop -> npc=0x300, pc_we=1.
REQ-025 suspend=1 with sync_we=1, sync_pc=0x400 -> same cycle npc=0x400, pc_we=1, pending discarded.
REQ-026 cpu_rst asserted in FLUSH -> next cycle state IDLE, counters 0; cur_pc=0xFFFFFFFC sequential -> npc=0x00000000.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg -- shared types for the next-PC redirect controller.
//   state_t : controller FSM states (IDLE / HOLD / FLUSH)
//   src_t   : redirect source encoding; lower non-zero value = higher priority
//   PC_INIT_VAL : PC value driven during reset and used as the cleared pend value
//   src_beats() : true when source a strictly outranks source b
package npc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Numeric order doubles as priority order (SYNC highest).
   typedef enum logic [2:0] {
      SRC_NONE = 3'd0,
      SRC_SYNC = 3'd1,
      SRC_EXC  = 3'd2,
      SRC_BR   = 3'd3,
      SRC_INC  = 3'd4
   } src_t;

   localparam logic [31:0] PC_INIT_VAL = 32'h0000_0000;

   function automatic logic src_beats(input src_t a, input src_t b);
      return (a != SRC_NONE) && ((b == SRC_NONE) || (a < b));
   endfunction

endpackage

// File: rtl/npc_redirect_ctrl_if.sv
// npc_redirect_ctrl_if -- redirect request bus plus the priority winner.
//   Request side : cur_pc, sync_we/sync_pc, exc_req/exc_pc, br_err/br_pc, sync_inc
//   Winner side  : win_src (src_t), win_pc (target of the winning request)
// Requests are level-qualified in the cycle they are presented; there is no
// ready back-pressure -- a request not taken in its cycle is either latched
// by the controller (stall) or simply gone.
//   master : drives requests, observes winner
//   slave  : observes requests, drives winner (the priority selector)
interface npc_redirect_ctrl_if
   import npc_pkg::*;
#(
   parameter int PC_WIDTH = 32
);
   logic [PC_WIDTH-1:0] cur_pc;
   logic                sync_we;
   logic [PC_WIDTH-1:0] sync_pc;
   logic                exc_req;
   logic [PC_WIDTH-1:0] exc_pc;
   logic                br_err;
   logic [PC_WIDTH-1:0] br_pc;
   logic                sync_inc;
   src_t                win_src;
   logic [PC_WIDTH-1:0] win_pc;

   modport master (
      output cur_pc, sync_we, sync_pc, exc_req, exc_pc, br_err, br_pc, sync_inc,
      input  win_src, win_pc
   );

   modport slave (
      input  cur_pc, sync_we, sync_pc, exc_req, exc_pc, br_err, br_pc, sync_inc,
      output win_src, win_pc
   );
endinterface

// File: rtl/npc_prio_sel.sv
// npc_prio_sel -- combinational fixed-priority pick of the redirect request.
//   bus (slave modport): request inputs in, win_src/win_pc out.
// Priority: sync_we > exc_req > br_err > sync_inc. sync_inc targets
// cur_pc+4, wrapping modulo 2^PC_WIDTH.
module npc_prio_sel
   import npc_pkg::*;
#(
   parameter int PC_WIDTH = 32
) (
   npc_redirect_ctrl_if.slave bus
);

   always_comb begin
      bus.win_src = SRC_NONE;
      bus.win_pc  = '0;
      if (bus.sync_we) begin
         bus.win_src = SRC_SYNC;
         bus.win_pc  = bus.sync_pc;
      end else if (bus.exc_req) begin
         bus.win_src = SRC_EXC;
         bus.win_pc  = bus.exc_pc;
      end else if (bus.br_err) begin
         bus.win_src = SRC_BR;
         bus.win_pc  = bus.br_pc;
      end else if (bus.sync_inc) begin
         bus.win_src = SRC_INC;
         bus.win_pc  = bus.cur_pc + PC_WIDTH'(4);
      end
   end

endmodule

// File: rtl/npc_redirect_ctrl.sv
// npc_redirect_ctrl -- next-PC select and redirect/flush sequencing.
//   Inputs : cpu_clk, cpu_rst (sync, active-high), suspend, cur_pc,
//            pred_taken/pred_target, sync_we/sync_pc, exc_req/exc_pc,
//            br_err/br_pc, sync_inc
//   Outputs: npc, pc_we, flush, if_valid, redir_busy, redir_cnt, mispred_cnt
// States: IDLE (sequential fetch), HOLD (redirect parked while stalled),
// FLUSH (flush kept high for FLUSH_CYCLES cycles counting the redirect cycle).
// All outputs are combinational from state, registers and inputs.
// Optional feature: define REDIRECT_STATS_EN to build the saturating
// redirect / mispredict counters; otherwise both ports read 0.
module npc_redirect_ctrl
   import npc_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int PC_WIDTH     = 32
) (
   input  logic                cpu_clk,
   input  logic                cpu_rst,
   input  logic                suspend,
   input  logic [PC_WIDTH-1:0] cur_pc,
   input  logic                pred_taken,
   input  logic [PC_WIDTH-1:0] pred_target,
   input  logic                sync_we,
   input  logic [PC_WIDTH-1:0] sync_pc,
   input  logic                exc_req,
   input  logic [PC_WIDTH-1:0] exc_pc,
   input  logic                br_err,
   input  logic [PC_WIDTH-1:0] br_pc,
   input  logic                sync_inc,
   output logic [PC_WIDTH-1:0] npc,
   output logic                pc_we,
   output logic                flush,
   output logic                if_valid,
   output logic                redir_busy,
   output logic [31:0]         redir_cnt,
   output logic [31:0]         mispred_cnt
);

   localparam logic [2:0]          CNT_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam state_t              ST_AFTER = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
   localparam logic [PC_WIDTH-1:0] PC_RST   = PC_WIDTH'(PC_INIT_VAL);

   npc_redirect_ctrl_if #(.PC_WIDTH(PC_WIDTH)) sel_if ();

   assign sel_if.cur_pc   = cur_pc;
   assign sel_if.sync_we  = sync_we;
   assign sel_if.sync_pc  = sync_pc;
   assign sel_if.exc_req  = exc_req;
   assign sel_if.exc_pc   = exc_pc;
   assign sel_if.br_err   = br_err;
   assign sel_if.br_pc    = br_pc;
   assign sel_if.sync_inc = sync_inc;

   npc_prio_sel #(.PC_WIDTH(PC_WIDTH)) u_prio_sel (
      .bus (sel_if.slave)
   );

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
   src_t                pend_src_q, pend_src_d;
   logic                issue;
   src_t                issue_src;
   logic [PC_WIDTH-1:0] issue_pc;
   logic [PC_WIDTH-1:0] seq_pc;

   assign seq_pc     = pred_taken ? pred_target : (cur_pc + PC_WIDTH'(4));
   assign redir_busy = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pend_pc_d  = pend_pc_q;
      pend_src_d = pend_src_q;
      npc        = seq_pc;
      pc_we      = 1'b0;
      flush      = 1'b0;
      if_valid   = 1'b0;
      issue      = 1'b0;
      issue_src  = SRC_NONE;
      issue_pc   = seq_pc;

      if (sel_if.win_src == SRC_SYNC) begin
         // Debug sync wins from any state regardless of stall.
         issue     = 1'b1;
         issue_src = SRC_SYNC;
         issue_pc  = sel_if.win_pc;
      end else begin
         case (state_q)
            IDLE, FLUSH: begin
               flush = (state_q == FLUSH);
               if (sel_if.win_src != SRC_NONE) begin
                  if (!suspend) begin
                     issue     = 1'b1;
                     issue_src = sel_if.win_src;
                     issue_pc  = sel_if.win_pc;
                  end else begin
                     pend_pc_d  = sel_if.win_pc;
                     pend_src_d = sel_if.win_src;
                     cnt_d      = '0;
                     state_d    = HOLD;
                  end
               end else begin
                  pc_we    = !suspend;
                  if_valid = !suspend && (state_q == IDLE);
                  if (state_q == FLUSH) begin
                     // Count runs through stalls; leave once it reaches zero.
                     cnt_d = cnt_q - 3'd1;
                     if (cnt_q <= 3'd1) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                     end
                  end
               end
            end
            HOLD: begin
               flush = 1'b1;
               if (!suspend) begin
                  issue = 1'b1;
                  if (src_beats(sel_if.win_src, pend_src_q)) begin
                     issue_src = sel_if.win_src;
                     issue_pc  = sel_if.win_pc;
                  end else begin
                     issue_src = pend_src_q;
                     issue_pc  = pend_pc_q;
                  end
               end else if (src_beats(sel_if.win_src, pend_src_q)) begin
                  pend_pc_d  = sel_if.win_pc;
                  pend_src_d = sel_if.win_src;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (issue) begin
         pc_we      = 1'b1;
         flush      = 1'b1;
         if_valid   = 1'b0;
         npc        = issue_pc;
         cnt_d      = CNT_LOAD;
         state_d    = ST_AFTER;
         pend_src_d = SRC_NONE;
         pend_pc_d  = PC_RST;
      end

      // Reset overrides outputs; register state is cleared in the flop block.
      if (cpu_rst) begin
         npc      = PC_RST;
         pc_we    = 1'b0;
         flush    = 1'b1;
         if_valid = 1'b0;
         issue    = 1'b0;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pend_pc_q  <= PC_RST;
         pend_src_q <= SRC_NONE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_pc_q  <= pend_pc_d;
         pend_src_q <= pend_src_d;
      end
   end

`ifdef REDIRECT_STATS_EN
   logic [31:0] redir_cnt_q, mispred_cnt_q;

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         redir_cnt_q   <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (issue && (redir_cnt_q != 32'hFFFF_FFFF))
            redir_cnt_q <= redir_cnt_q + 32'd1;
         if (issue && (issue_src == SRC_BR) && (mispred_cnt_q != 32'hFFFF_FFFF))
            mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign redir_cnt   = redir_cnt_q;
   assign mispred_cnt = mispred_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = ^{issue, issue_src};
   assign redir_cnt    = '0;
   assign mispred_cnt  = '0;
`endif

endmodule
